// File: rtl/riscboy_ppu_lcd_seq.sv
// Command-list sequencer for the PPU LCD shifter path.
// Walks a 16-bit command list held in a 1-cycle-latency sync memory and pushes
// command bytes / pixel data into the pixel FIFO write side. Owns lcd_cs,
// lcd_dc and lcd_shamt, and only retargets dc/shamt once the shifter path
// (FIFO plus shifter) has fully drained.
module riscboy_ppu_lcd_seq #(
  parameter int W_ADDR  = 8,
  parameter int W_SHAMT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [W_ADDR-1:0]  list_base,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [W_ADDR-1:0]  mem_addr,
  output logic               mem_ren,
  input  logic [15:0]        mem_rdata,
  output logic [15:0]        pxfifo_wdata,
  output logic               pxfifo_wen,
  input  logic               pxfifo_full,
  input  logic               pxfifo_empty,
  input  logic               tx_busy,
  output logic               lcd_cs,
  output logic               lcd_dc,
  output logic [W_SHAMT-1:0] lcd_shamt
);

  typedef enum logic [3:0] {
    IDLE, FETCH, RDWAIT, DECODE, DRAIN, PUSH, FETCH2, RDWAIT2, DELAY, FLUSH
  } state_t;

  typedef enum logic [2:0] {
    OP_CMD   = 3'b000,
    OP_DAT8  = 3'b001,
    OP_DAT16 = 3'b010,
    OP_DELAY = 3'b011,
    OP_END   = 3'b111
  } opcode_t;

  localparam logic [W_SHAMT-1:0] SH8  = W_SHAMT'(8);
  localparam logic [W_SHAMT-1:0] SH16 = W_SHAMT'(16);

  state_t              state;
  logic [W_ADDR-1:0]   ptr;
  logic [15:0]         cmd;
  logic [12:0]         dly;
  logic                req_dc;
  logic                req_sh16;
  logic                abort_pend;

  logic                drained;
  opcode_t             op;
  logic                dec_dc;
  logic [W_SHAMT-1:0]  dec_sh;

  assign drained = pxfifo_empty && !tx_busy;
  assign op      = opcode_t'(cmd[15:13]);
  assign dec_dc  = (op != OP_CMD);
  assign dec_sh  = (op == OP_DAT16) ? SH16 : SH8;

  // The push strobe depends on the live full flag so a push can never land on
  // a full FIFO; read strobe and address follow the fetch states directly.
  assign mem_ren    = (state == FETCH) || (state == FETCH2);
  assign mem_addr   = ptr;
  assign pxfifo_wen = (state == PUSH) && !pxfifo_full;

  // Sequencer state, list pointer and registered panel-control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      cmd          <= '0;
      dly          <= '0;
      req_dc       <= 1'b1;
      req_sh16     <= 1'b1;
      abort_pend   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      pxfifo_wdata <= '0;
      lcd_cs       <= 1'b1;
      lcd_dc       <= 1'b1;
      lcd_shamt    <= SH16;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            ptr        <= list_base;
            err        <= 1'b0;
            busy       <= 1'b1;
            lcd_cs     <= 1'b0;
            abort_pend <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          ptr   <= ptr + W_ADDR'(1);
          state <= abort ? FLUSH : RDWAIT;
        end
        RDWAIT: begin
          cmd   <= mem_rdata;
          state <= abort ? FLUSH : DECODE;
        end
        DECODE: begin
          if (abort) begin
            state <= FLUSH;
          end else begin
            case (op)
              OP_CMD, OP_DAT8, OP_DAT16: begin
                req_dc       <= dec_dc;
                req_sh16     <= (op == OP_DAT16);
                pxfifo_wdata <= {cmd[7:0], 8'h00};
                if (lcd_dc == dec_dc && lcd_shamt == dec_sh)
                  state <= (op == OP_DAT16) ? FETCH2 : PUSH;
                else
                  state <= DRAIN;
              end
              OP_DELAY: begin
                if (cmd[12:0] == 13'd0) begin
                  state <= FETCH;
                end else begin
                  dly   <= cmd[12:0] - 13'd1;
                  state <= DELAY;
                end
              end
              OP_END: state <= FLUSH;
              default: begin
                err   <= 1'b1;
                state <= FLUSH;
              end
            endcase
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= FLUSH;
          end else if (drained) begin
            lcd_dc    <= req_dc;
            lcd_shamt <= req_sh16 ? SH16 : SH8;
            state     <= req_sh16 ? FETCH2 : PUSH;
          end
        end
        // An abort seen while stalled on a full FIFO is remembered so the
        // pending entry is still pushed before the list is wound down.
        PUSH: begin
          if (!pxfifo_full)
            state <= (abort || abort_pend) ? FLUSH : FETCH;
          else if (abort)
            abort_pend <= 1'b1;
        end
        FETCH2: begin
          ptr   <= ptr + W_ADDR'(1);
          state <= abort ? FLUSH : RDWAIT2;
        end
        RDWAIT2: begin
          pxfifo_wdata <= mem_rdata;
          state        <= abort ? FLUSH : PUSH;
        end
        DELAY: begin
          if (abort)
            state <= FLUSH;
          else if (dly == 13'd0)
            state <= FETCH;
          else
            dly <= dly - 13'd1;
        end
        FLUSH: begin
          if (drained) begin
            lcd_cs <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
